// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: FSM state encoding and INT_IRQ source codes.
package int_ctrl_pkg;

  localparam int N_SRC = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ASSERT  = ST_ASSERT,
    S_SERVICE = ST_SERVICE
  } state_e;

  localparam logic [1:0] IRQ_NONE  = 2'd0;
  localparam logic [1:0] IRQ_TIMER = 2'd1;
  localparam logic [1:0] IRQ_KBD   = 2'd2;
  localparam logic [1:0] IRQ_GPU   = 2'd3;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest eligible index wins, giving both its INT_IRQ code and a one-hot select.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [N_SRC-1:0] eligible,
  output logic [1:0]       code,
  output logic [N_SRC-1:0] sel
);

  always_comb begin
    // NOTE: defaults assigned first so every path drives every output; no latch is inferred.
    code = IRQ_NONE;
    sel  = '0;
    if (eligible[0]) begin
      code = IRQ_TIMER;
      sel  = 3'b001;
    end else if (eligible[1]) begin
      code = IRQ_KBD;
      sel  = 3'b010;
    end else if (eligible[2]) begin
      code = IRQ_GPU;
      sel  = 3'b100;
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Responder side of the processor interrupt handshake: pending latch, priority pick,
// and the IDLE -> ASSERT -> SERVICE handshake with sticky overrun / protocol-error flags.
module interrupt_controller
  import int_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_SRC-1:0] SRC_REQ,
  input  logic [N_SRC-1:0] SRC_MASK,
  output logic [1:0]       INT_IRQ,
  input  logic             INT_IACK,
  input  logic             INT_IEND,
  output logic             IN_SERVICE,
  output logic [N_SRC-1:0] PENDING,
  output logic [N_SRC-1:0] OVERRUN,
  output logic             PROTO_ERR
);

  state_e           state;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] win_sel;
  logic [1:0]       win_code;
  logic [N_SRC-1:0] ack_sel;
  logic [N_SRC-1:0] clear;
  logic             take_iack;
  logic             bad_proto;

  assign eligible = PENDING & ~SRC_MASK;

  int_prio_enc u_prio (
    .eligible (eligible),
    .code     (win_code),
    .sel      (win_sel)
  );

  // ack_sel remembers which source was presented, so the acknowledge clears exactly that bit.
  assign take_iack = (state == S_ASSERT) && INT_IACK;
  assign clear     = take_iack ? ack_sel : '0;
  assign bad_proto = (INT_IEND && state != S_SERVICE) || (INT_IACK && state != S_ASSERT);

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      INT_IRQ    <= IRQ_NONE;
      IN_SERVICE <= 1'b0;
      PENDING    <= '0;
      OVERRUN    <= '0;
      PROTO_ERR  <= 1'b0;
      ack_sel    <= '0;
    end else begin
      // A request on its own acknowledge edge re-sets the bit and is not an overrun.
      PENDING <= (PENDING & ~clear) | SRC_REQ;
      OVERRUN <= OVERRUN | (SRC_REQ & PENDING & ~clear);
      if (bad_proto) PROTO_ERR <= 1'b1;

      case (state)
        S_IDLE: begin
          if (|eligible) begin
            state   <= S_ASSERT;
            INT_IRQ <= win_code;
            ack_sel <= win_sel;
          end
        end
        S_ASSERT: begin
          if (INT_IACK) begin
            state      <= S_SERVICE;
            IN_SERVICE <= 1'b1;
          end
        end
        S_SERVICE: begin
          if (INT_IEND) begin
            state      <= S_IDLE;
            IN_SERVICE <= 1'b0;
            INT_IRQ    <= IRQ_NONE;
          end
        end
        default: begin
          state      <= S_IDLE;
          IN_SERVICE <= 1'b0;
          INT_IRQ    <= IRQ_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed self-checking bench for interrupt_controller; outputs sampled 1 time unit after each rising edge.
module tb_interrupt_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [2:0] SRC_REQ;
  logic [2:0] SRC_MASK;
  logic [1:0] INT_IRQ;
  logic       INT_IACK;
  logic       INT_IEND;
  logic       IN_SERVICE;
  logic [2:0] PENDING;
  logic [2:0] OVERRUN;
  logic       PROTO_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_controller dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SRC_REQ    (SRC_REQ),
    .SRC_MASK   (SRC_MASK),
    .INT_IRQ    (INT_IRQ),
    .INT_IACK   (INT_IACK),
    .INT_IEND   (INT_IEND),
    .IN_SERVICE (IN_SERVICE),
    .PENDING    (PENDING),
    .OVERRUN    (OVERRUN),
    .PROTO_ERR  (PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge; inputs set before this call are sampled on that edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " irq"},     32'(INT_IRQ),    32'd0);
    check({tag, " insvc"},   32'(IN_SERVICE), 32'd0);
    check({tag, " pending"}, 32'(PENDING),    32'd0);
    check({tag, " overrun"}, 32'(OVERRUN),    32'd0);
    check({tag, " proto"},   32'(PROTO_ERR),  32'd0);
  endtask

  initial begin
    RESET = 1'b1; SRC_REQ = '0; SRC_MASK = '0; INT_IACK = 1'b0; INT_IEND = 1'b0;
    step(); step();
    RESET = 1'b0;
    check_all_zero("reset");

    // Single keyboard request through full handshake
    SRC_REQ = 3'b010; step(); SRC_REQ = '0;
    check("single pending", 32'(PENDING), 32'd2);
    check("single irq latency", 32'(INT_IRQ), 32'd0);
    step();
    check("single irq", 32'(INT_IRQ), 32'd2);
    check("single not insvc", 32'(IN_SERVICE), 32'd0);
    step(); step();
    check("single irq hold", 32'(INT_IRQ), 32'd2);
    INT_IACK = 1'b1; step(); INT_IACK = 1'b0;
    check("single ack pending", 32'(PENDING), 32'd0);
    check("single ack insvc", 32'(IN_SERVICE), 32'd1);
    check("single ack irq", 32'(INT_IRQ), 32'd2);
    step();
    INT_IEND = 1'b1; step(); INT_IEND = 1'b0;
    check("single end irq", 32'(INT_IRQ), 32'd0);
    check("single end insvc", 32'(IN_SERVICE), 32'd0);
    check("single proto", 32'(PROTO_ERR), 32'd0);

    // Priority and no preemption
    SRC_REQ = 3'b110; step(); SRC_REQ = '0; step();
    check("prio first", 32'(INT_IRQ), 32'd2);
    SRC_REQ = 3'b001; step(); SRC_REQ = '0;
    check("prio no preempt", 32'(INT_IRQ), 32'd2);
    check("prio pending all", 32'(PENDING), 32'd7);
    INT_IACK = 1'b1; step(); INT_IACK = 1'b0;
    check("prio ack irq", 32'(INT_IRQ), 32'd2);
    check("prio ack pending", 32'(PENDING), 32'd5);
    INT_IEND = 1'b1; step(); INT_IEND = 1'b0;
    check("prio gap", 32'(INT_IRQ), 32'd0);
    step();
    check("prio timer", 32'(INT_IRQ), 32'd1);
    INT_IACK = 1'b1; step(); INT_IACK = 1'b0;
    check("prio timer ack pending", 32'(PENDING), 32'd4);
    INT_IEND = 1'b1; step(); INT_IEND = 1'b0;
    check("prio gap2", 32'(INT_IRQ), 32'd0);
    step();
    check("prio gpu", 32'(INT_IRQ), 32'd3);
    INT_IACK = 1'b1; step(); INT_IACK = 1'b0;
    INT_IEND = 1'b1; step(); INT_IEND = 1'b0;
    check("prio done irq", 32'(INT_IRQ), 32'd0);
    check("prio done pending", 32'(PENDING), 32'd0);
    check("prio overrun", 32'(OVERRUN), 32'd0);

    // Mask: latched but never presented until unmasked
    SRC_MASK = 3'b001; SRC_REQ = 3'b001; step(); SRC_REQ = '0;
    check("mask pending", 32'(PENDING), 32'd1);
    step(); step();
    check("mask irq held off", 32'(INT_IRQ), 32'd0);
    SRC_MASK = '0; step(); step();
    check("unmask irq", 32'(INT_IRQ), 32'd1);
    INT_IACK = 1'b1; step(); INT_IACK = 1'b0;
    INT_IEND = 1'b1; step(); INT_IEND = 1'b0;
    check("mask done pending", 32'(PENDING), 32'd0);

    // Overrun, then set-beats-clear on the acknowledge edge
    SRC_REQ = 3'b010; step(); SRC_REQ = '0; step();
    SRC_REQ = 3'b010; step(); SRC_REQ = '0;
    check("overrun set", 32'(OVERRUN), 32'd2);
    check("overrun pending", 32'(PENDING), 32'd2);
    SRC_REQ = 3'b010; INT_IACK = 1'b1; step(); SRC_REQ = '0; INT_IACK = 1'b0;
    check("sbc pending", 32'(PENDING), 32'd2);
    check("sbc overrun", 32'(OVERRUN), 32'd2);
    check("sbc insvc", 32'(IN_SERVICE), 32'd1);
    INT_IEND = 1'b1; step(); INT_IEND = 1'b0;
    step();
    check("sbc re-present", 32'(INT_IRQ), 32'd2);
    INT_IACK = 1'b1; step(); INT_IACK = 1'b0;
    INT_IEND = 1'b1; step(); INT_IEND = 1'b0;
    check("sbc proto clean", 32'(PROTO_ERR), 32'd0);

    // Protocol errors
    INT_IEND = 1'b1; step(); INT_IEND = 1'b0;
    check("iend idle proto", 32'(PROTO_ERR), 32'd1);
    check("iend idle insvc", 32'(IN_SERVICE), 32'd0);
    check("iend idle irq", 32'(INT_IRQ), 32'd0);
    SRC_REQ = 3'b100; step(); SRC_REQ = '0; step();
    INT_IACK = 1'b1; step(); INT_IACK = 1'b0;
    check("svc entered", 32'(IN_SERVICE), 32'd1);
    INT_IACK = 1'b1; step(); INT_IACK = 1'b0;
    check("iack svc insvc", 32'(IN_SERVICE), 32'd1);
    check("iack svc irq", 32'(INT_IRQ), 32'd3);
    check("iack svc proto", 32'(PROTO_ERR), 32'd1);

    // Reset mid-service with pending requests and sticky flags set
    SRC_REQ = 3'b101; step(); SRC_REQ = '0;
    check("pre-reset pending", 32'(PENDING), 32'd5);
    RESET = 1'b1; step(); RESET = 1'b0;
    check_all_zero("mid reset");
    step();
    check("post reset irq", 32'(INT_IRQ), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
